// File: rtl/rc4_encrypt.sv
// rc4_encrypt: RC4 engine that encrypts a plaintext ROM into a ciphertext RAM using a 3-byte key
module rc4_encrypt #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  output logic [4:0]  p_address,
  input  logic [7:0]  p_q,
  output logic [4:0]  c_address,
  output logic [7:0]  c_data,
  output logic        c_wren
);
  typedef enum logic [4:0] {
    IDLE, FILL,
    KS_READ_I, KS_WAIT_I, KS_READ_J, KS_WAIT_J, KS_WRITE_I, KS_WRITE_J,
    PR_INIT, PR_INC_I, PR_WAIT_I, PR_READ_J, PR_WAIT_J, PR_WRITE_I, PR_WRITE_J,
    PR_READ_F, PR_WAIT_F, PR_WRITE_OUT, DONE
  } state_t;
  state_t      r_state;
  logic [23:0] r_key;
  logic [7:0]  r_i, r_j, r_si, r_sj, r_pt;
  logic [4:0]  r_k;
  logic [1:0]  r_kidx;
  logic        r_busy, r_done;
  logic [7:0]  w_kb, w_ks_j, w_pr_j, w_i_inc, w_f_addr;
  assign w_kb     = r_kidx == 2'd0 ? r_key[23:16] : r_kidx == 2'd1 ? r_key[15:8] : r_key[7:0];
  assign w_ks_j   = r_j + s_q + w_kb;
  assign w_pr_j   = r_j + s_q;
  assign w_i_inc  = r_i + 8'd1;
  assign w_f_addr = r_si + r_sj;
  assign busy     = r_busy;
  assign done     = r_done;
  // Memory buses are decoded from the registered state so each read address is
  // held across the read and wait states and write data can come straight from s_q.
  always_comb begin
    s_address = 8'd0;
    s_data    = 8'd0;
    s_wren    = 1'b0;
    p_address = r_k;
    c_address = r_k;
    c_data    = 8'd0;
    c_wren    = 1'b0;
    case (r_state)
      FILL: begin
        s_address = r_i;
        s_data    = r_i;
        s_wren    = 1'b1;
      end
      KS_READ_I, KS_WAIT_I, PR_WAIT_I: s_address = r_i;
      KS_READ_J:                       s_address = w_ks_j;
      PR_READ_J:                       s_address = w_pr_j;
      KS_WAIT_J, PR_WAIT_J:            s_address = r_j;
      PR_INC_I:                        s_address = w_i_inc;
      KS_WRITE_I, PR_WRITE_I: begin
        s_address = r_i;
        s_data    = s_q;
        s_wren    = 1'b1;
      end
      KS_WRITE_J, PR_WRITE_J: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
      end
      PR_READ_F, PR_WAIT_F:            s_address = w_f_addr;
      PR_WRITE_OUT: begin
        s_address = w_f_addr;
        c_data    = s_q ^ r_pt;
        c_wren    = 1'b1;
      end
      default: ;
    endcase
  end
  // Control FSM: fill, key schedule, keystream generation and the start/done handshake.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_key   <= 24'd0;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= 5'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_pt    <= 8'd0;
      r_kidx  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_key   <= key;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_i     <= 8'd0;
          r_state <= FILL;
        end
        FILL: begin
          r_i    <= w_i_inc;
          r_j    <= 8'd0;
          r_kidx <= 2'd0;
          if (r_i == 8'hFF) r_state <= KS_READ_I;
        end
        KS_READ_I: r_state <= KS_WAIT_I;
        KS_WAIT_I: r_state <= KS_READ_J;
        KS_READ_J: begin
          r_si    <= s_q;
          r_j     <= w_ks_j;
          r_state <= KS_WAIT_J;
        end
        KS_WAIT_J:  r_state <= KS_WRITE_I;
        KS_WRITE_I: r_state <= KS_WRITE_J;
        KS_WRITE_J: begin
          r_i     <= w_i_inc;
          r_kidx  <= r_kidx == 2'(KEY_BYTES - 1) ? 2'd0 : r_kidx + 2'd1;
          r_state <= r_i == 8'hFF ? PR_INIT : KS_READ_I;
        end
        PR_INIT: begin
          r_i     <= 8'd0;
          r_j     <= 8'd0;
          r_k     <= 5'd0;
          r_state <= PR_INC_I;
        end
        PR_INC_I: begin
          r_i     <= w_i_inc;
          r_state <= PR_WAIT_I;
        end
        PR_WAIT_I: r_state <= PR_READ_J;
        PR_READ_J: begin
          r_si    <= s_q;
          r_j     <= w_pr_j;
          r_pt    <= p_q;
          r_state <= PR_WAIT_J;
        end
        PR_WAIT_J: r_state <= PR_WRITE_I;
        PR_WRITE_I: begin
          r_sj    <= s_q;
          r_state <= PR_WRITE_J;
        end
        PR_WRITE_J: r_state <= PR_READ_F;
        PR_READ_F:  r_state <= PR_WAIT_F;
        PR_WAIT_F:  r_state <= PR_WRITE_OUT;
        PR_WRITE_OUT: begin
          if (r_k == 5'(MSG_LEN - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k     <= r_k + 5'd1;
            r_state <= PR_INC_I;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_encrypt.sv
// tb_rc4_encrypt: directed-vector bench for rc4_encrypt with behavioural S RAM, plaintext ROM and ciphertext RAM
module tb_rc4_encrypt;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] key = 24'd0;
  logic        busy, done, s_wren, c_wren;
  logic [7:0]  s_address, s_data, s_q, p_q, c_data;
  logic [4:0]  p_address, c_address;
  logic [7:0]  s_mem [256];
  logic [7:0]  p_mem [32];
  logic [7:0]  c_mem [32];
  logic        clr_c = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_total = 0;
  int          busy_total = 0;
  int          fill_idx = 0;
  int          fill_last = 0;
  bit          fill_live = 1'b0;
  logic [7:0]  v1_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0]  v1_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0]  ks_ref [5] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7};
  string       text = "the quick brown fox jumps over t";

  rc4_encrypt #(.MSG_LEN(32), .KEY_BYTES(3)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .p_address(p_address), .p_q(p_q),
    .c_address(c_address), .c_data(c_data), .c_wren(c_wren)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous memories: registered read data, write on the clock edge
  always @(posedge CLOCK_50) begin
    if (s_wren) s_mem[s_address] <= s_data;
    s_q <= s_mem[s_address];
    p_q <= p_mem[p_address];
    if (clr_c) for (int a = 0; a < 32; a++) c_mem[a] <= 8'h00;
    else if (c_wren) c_mem[c_address] <= c_data;
  end

  // Free-running activity counters and FILL sequence tracker
  always @(negedge CLOCK_50) begin
    if (c_wren) wr_total++;
    if (busy) busy_total++;
    if (!busy) begin
      fill_idx  = 0;
      fill_live = 1'b1;
    end else if (fill_live && s_wren && s_address == fill_idx[7:0] && s_data == fill_idx[7:0])
      fill_idx++;
    else if (fill_live) begin
      fill_last = fill_idx;
      fill_live = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_c();
    @(negedge CLOCK_50);
    clr_c = 1'b1;
    @(negedge CLOCK_50);
    clr_c = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLOCK_50);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge CLOCK_50);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic run(input logic [23:0] k, input bit poke, output int wr, output int cyc);
    int wr0, b0;
    clear_c();
    wr0   = wr_total;
    b0    = busy_total;
    key   = k;
    start = 1'b1;
    wait_busy("accept");
    start = 1'b0;
    if (poke) begin
      repeat (500) @(negedge CLOCK_50);
      key   = ~k;
      start = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      start = 1'b0;
    end
    wait_done("done_timeout");
    wr  = wr_total - wr0;
    cyc = busy_total - b0;
  endtask

  task automatic load_v1();
    for (int a = 0; a < 32; a++) p_mem[a] = a < 9 ? v1_pt[a] : 8'h00;
  endtask

  task automatic check_v1(input string tag);
    int bad = 0;
    for (int a = 0; a < 9; a++) if (c_mem[a] !== v1_ct[a]) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", tag, a, c_mem[a], v1_ct[a]);
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int wr, cyc, bad, distinct;
    bit seen [256];
    for (int a = 0; a < 32; a++) p_mem[a] = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_wren", 32'(s_wren), 32'd0);
    check("rst_c_wren", 32'(c_wren), 32'd0);
    check("rst_s_address", 32'(s_address), 32'd0);
    check("rst_c_data", 32'(c_data), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    load_v1();
    run(24'h4B6579, 1'b0, wr, cyc);
    check_v1("v1_ct");
    check("v1_done", 32'(done), 32'd1);
    check("v1_busy_low", 32'(busy), 32'd0);
    check("v1_wr_pulses", 32'(wr), 32'd32);
    check("v1_cycles", 32'(cyc), 32'd2081);
    check("fill_len", 32'(fill_last), 32'd256);

    for (int a = 0; a < 32; a++) p_mem[a] = 8'h00;
    run(24'h4B6579, 1'b0, wr, cyc);
    for (int a = 0; a < 5; a++) check($sformatf("keystream[%0d]", a), 32'(c_mem[a]), 32'(ks_ref[a]));
    distinct = 0;
    for (int a = 0; a < 256; a++) seen[a] = 1'b0;
    for (int a = 0; a < 256; a++) seen[s_mem[a]] = 1'b1;
    for (int a = 0; a < 256; a++) if (seen[a]) distinct++;
    check("s_permutation", 32'(distinct), 32'd256);

    for (int a = 0; a < 32; a++) p_mem[a] = text[a];
    run(24'h000123, 1'b0, wr, cyc);
    check("rt_cycles", 32'(cyc), 32'd2081);
    bad = 0;
    for (int a = 0; a < 32; a++) if (c_mem[a] === text[a]) bad++;
    check("rt_ct_differs", 32'(bad < 32), 32'd1);
    for (int a = 0; a < 32; a++) p_mem[a] = c_mem[a];
    run(24'h000123, 1'b0, wr, cyc);
    bad = 0;
    for (int a = 0; a < 32; a++) if (c_mem[a] !== text[a]) begin
      bad++;
      $display("FAIL rt_byte[%0d]: got %0h expected %0h", a, c_mem[a], text[a]);
    end
    check("rt_roundtrip", 32'(bad), 32'd0);

    load_v1();
    key   = 24'h4B6579;
    start = 1'b1;
    wait_busy("ks_accept");
    start = 1'b0;
    repeat (256 + 600) @(negedge CLOCK_50);
    check("ks_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s_wren", 32'(s_wren), 32'd0);
    check("abort_c_wren", 32'(c_wren), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    run(24'h4B6579, 1'b0, wr, cyc);
    check_v1("post_abort_ct");

    run(24'h4B6579, 1'b1, wr, cyc);
    check_v1("poke_ct");
    check("poke_cycles", 32'(cyc), 32'd2081);
    check("poke_wr_pulses", 32'(wr), 32'd32);

    clear_c();
    key   = 24'h4B6579;
    start = 1'b1;
    wait_busy("hold_accept");
    wait_done("hold_done1");
    check_v1("hold_run1_ct");
    wr = wr_total;
    @(negedge CLOCK_50);
    check("hold_rerun_busy", 32'(busy), 32'd1);
    check("hold_rerun_done", 32'(done), 32'd0);
    clr_c = 1'b1;
    @(negedge CLOCK_50);
    clr_c = 1'b0;
    start = 1'b0;
    wait_done("hold_done2");
    check_v1("hold_run2_ct");
    check("hold_run2_wr", 32'(wr_total - wr), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
